regfile_write_arbiter: RTL and testbench

//  Shares the single write port (W, W_Adr, we) of the 8x16 register file between two writeback

---
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port (we, W_Adr, W) of the 8x16 register file
//   between two writeback requesters, A (ALU result) and B (memory load),
//   using round-robin arbitration over valid/ready handshakes. It also runs
//   a clear sweep that writes zero to every register, one per cycle.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   a_valid/a_adr/a_data  requester A write request
//   a_ready               A accepted this cycle (combinational)
//   b_valid/b_adr/b_data  requester B write request
//   b_ready               B accepted this cycle (combinational)
//   clr_req               one-cycle pulse that starts the clear sweep
//   clr_busy              clear sweep in progress
//   we, W_Adr, W          registered register-file write port
//
// Configuration macro
//   REGFILE_ARB_R0_ZERO_EN  register 0 is hardwired zero: writes to address 0
//                           still handshake but do not assert we, and the
//                           clear sweep covers registers 1..NREGS-1 only.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADR_W-1:0]  a_adr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADR_W-1:0]  b_adr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              we,
  output logic [ADR_W-1:0]  W_Adr,
  output logic [DATA_W-1:0] W
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam logic [ADR_W-1:0] CLR_FIRST = ADR_W'(1);
`else
  localparam logic [ADR_W-1:0] CLR_FIRST = '0;
`endif
  localparam logic [ADR_W-1:0] CLR_LAST = ADR_W'(NREGS - 1);

  state_t           state;
  logic [ADR_W-1:0] count;
  logic             last_grant;
  logic             arb_ok;

  // True when an accepted write to this address must reach the register file.
  function automatic logic adr_writable(input logic [ADR_W-1:0] adr);
`ifdef REGFILE_ARB_R0_ZERO_EN
    return adr != '0;
`else
    return (adr == adr); // every address is an ordinary register
`endif
  endfunction

  // clr_busy stays high one cycle past the CLEAR state so that the cycle
  // carrying the last clear write on the outputs is still closed to
  // requesters. A clr_req pulse wins over any valid in the same cycle.
  always_comb begin
    arb_ok  = !reset && (state == IDLE) && !clr_busy && !clr_req;
    a_ready = arb_ok && a_valid && (!b_valid || last_grant == LG_B);
    b_ready = arb_ok && b_valid && (!a_valid || last_grant == LG_A);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= LG_B;
      clr_busy   <= 1'b0;
      we         <= 1'b0;
      W_Adr      <= '0;
      W          <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req && !clr_busy) begin
            state    <= CLEAR;
            count    <= CLR_FIRST;
            clr_busy <= 1'b1;
          end else begin
            clr_busy <= 1'b0;
            if (a_ready) begin
              last_grant <= LG_A;
              if (adr_writable(a_adr)) begin
                we    <= 1'b1;
                W_Adr <= a_adr;
                W     <= a_data;
              end
            end else if (b_ready) begin
              last_grant <= LG_B;
              if (adr_writable(b_adr)) begin
                we    <= 1'b1;
                W_Adr <= b_adr;
                W     <= b_data;
              end
            end
          end
        end
        CLEAR: begin
          we    <= 1'b1;
          W_Adr <= count;
          W     <= '0;
          if (count == CLR_LAST) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter. Each step drives inputs,
//   checks the combinational readies and clr_busy for the current cycle,
//   queues the write expected on the registered port one cycle later, then
//   clocks and compares against the queue head.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, clr_req;
  logic [2:0]  a_adr, b_adr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, clr_busy, we;
  logic [2:0]  W_Adr;
  logic [15:0] W;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam int CLR_START = 1;
  localparam logic R0_WE   = 1'b0;
`else
  localparam int CLR_START = 0;
  localparam logic R0_WE   = 1'b1;
`endif

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_adr(a_adr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_adr(b_adr), .b_data(b_data), .b_ready(b_ready),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .we(we), .W_Adr(W_Adr), .W(W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step: check current-cycle handshake outputs, queue the
  // expected registered write, clock, then compare with the queue head.
  task automatic tick(input string tag, input logic ea, input logic eb,
                      input logic ebusy, input logic ewe,
                      input logic [2:0] eadr, input logic [15:0] edata);
    exp_t e, got;
    #1;
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(ea));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(eb));
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'(ebusy));
    e.we = ewe; e.adr = eadr; e.data = edata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.we = we; got.adr = W_Adr; got.data = W;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".write"}, 32'(got), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; clr_req = 1'b0;
    a_valid = 1'b0; a_adr = '0; a_data = '0;
    b_valid = 1'b0; b_adr = '0; b_data = '0;
    @(posedge clk); #1;

    // Reset state, with a stray valid that reset must override
    a_valid = 1'b1; a_adr = 3'd6; a_data = 16'h6666;
    tick("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

    // Single A write
    reset = 1'b0; a_adr = 3'd3; a_data = 16'hBEEF;
    tick("a_only", 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF);
    a_valid = 1'b0;

    // Idle cycles hold the last address and data
    for (int i = 0; i < 3; i++)
      tick("idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'hBEEF);

    // Round robin from a fresh reset: A wins the first tie
    reset = 1'b1;
    tick("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    reset = 1'b0;
    a_valid = 1'b1; a_adr = 3'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_adr = 3'd2; b_data = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      tick("rr_a", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1111);
      tick("rr_b", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h2222);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Clear with a simultaneous A request: the clear wins
    a_valid = 1'b1; a_adr = 3'd5; a_data = 16'h5555; clr_req = 1'b1;
    tick("clr_start", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h2222);
    clr_req = 1'b0;
    for (int k = CLR_START; k < 8; k++)
      tick("clr_sweep", 1'b0, 1'b0, 1'b1, 1'b1, 3'(k), 16'h0);
    // Cycle carrying the W_Adr=7 write: still busy, no grant
    tick("clr_tail", 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0);
    tick("clr_resume", 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 16'h5555);
    a_valid = 1'b0;

    // Reset in the cycle that carries the W_Adr=4 clear write
    clr_req = 1'b1;
    tick("clr2_start", 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5555);
    clr_req = 1'b0;
    for (int k = CLR_START; k <= 4; k++)
      tick("clr2_sweep", 1'b0, 1'b0, 1'b1, 1'b1, 3'(k), 16'h0);
    reset = 1'b1;
    tick("clr2_abort", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      tick("clr2_dead", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

    // Write to register 0 from B
    b_valid = 1'b1; b_adr = 3'd0; b_data = 16'hFFFF;
    tick("r0_write", 1'b0, 1'b1, 1'b0, R0_WE, 3'd0,
         (R0_WE == 1'b1) ? 16'hFFFF : 16'h0000);
    b_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // At most one ready per cycle
  always @(negedge clk) begin
    if (a_ready && b_ready) begin
      bad++;
      $error("FAIL both_ready observed=11 expected=not both");
    end
  end

endmodule
